// File: rtl/bcd_serial_addsub_if.sv
// Handshake/data bundle for the serial BCD adder/subtractor.
//   start, op, a, b          : request side (driven by master)
//   busy, done, result, cout,
//   neg, err                 : status/result side (driven by slave)
interface bcd_serial_addsub_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  op;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  neg;
  logic                  err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, neg, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, neg, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction adds the 10's complement of b (9's complement plus an initial
// carry of 1); a missing final carry means a < b, and a second serial pass
// takes the 10's complement of the partial result to recover |a-b|.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of bcd_serial_addsub_if (start/op/a/b in,
//          busy/done/result/cout/neg/err out)
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input logic                 clk,
  input logic                 rst,
  bcd_serial_addsub_if.slave  bus
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = $clog2(DIGITS);

  typedef enum logic [1:0] {StIdle, StAdd, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      res_q, res_d;
  logic              op_q, op_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              neg_q, neg_d;
  logic              err_q, err_d;

  logic              bad_digit;
  logic [3:0]        add_x, add_y, sum_digit;
  logic [4:0]        raw_sum;
  logic              sum_carry;
  logic              last_digit;

  // Any non-decimal nibble in the incoming operands.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Single decimal digit adder shared by the ADD and FIX passes.
  // FIX: t = (9 - r_i) + c. ADD: s = a_i + (op ? 9 - b_i : b_i) + c.
  always_comb begin
    add_x = a_q[3:0];
    add_y = op_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    if (state_q == StFix) begin
      add_x = 4'd9 - res_q[3:0];
      add_y = 4'd0;
    end
    raw_sum = {1'b0, add_x} + {1'b0, add_y} + {4'b0000, carry_q};
    if (raw_sum > 5'd9) begin
      sum_digit = 4'(raw_sum - 5'd10);
      sum_carry = 1'b1;
    end else begin
      sum_digit = raw_sum[3:0];
      sum_carry = 1'b0;
    end
  end

  assign last_digit = (idx_q == IdxW'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          idx_d   = '0;
          carry_d = bus.op;
          cout_d  = 1'b0;
          neg_d   = 1'b0;
          err_d   = 1'b0;
          if (bad_digit) begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = StDone;
          end else begin
            state_d = StAdd;
          end
        end
      end

      StAdd: begin
        // Digits enter at the top and are fully aligned after DIGITS shifts.
        res_d   = {sum_digit, res_q[W-1:4]};
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = sum_carry;
        idx_d   = idx_q + IdxW'(1);
        if (last_digit) begin
          idx_d = '0;
          if (!op_q) begin
            cout_d  = sum_carry;
            state_d = StDone;
          end else if (sum_carry) begin
            neg_d   = 1'b0;
            state_d = StDone;
          end else begin
            carry_d = 1'b1;
            state_d = StFix;
          end
        end
      end

      StFix: begin
        res_d   = {sum_digit, res_q[W-1:4]};
        carry_d = sum_carry;
        idx_d   = idx_q + IdxW'(1);
        if (last_digit) begin
          idx_d   = '0;
          neg_d   = 1'b1;
          state_d = StDone;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy   = (state_q == StAdd) || (state_q == StFix);
  assign bus.done   = (state_q == StDone);
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomized self-checking bench for bcd_serial_addsub (DIGITS = 4).
// Expected values come from integer decimal arithmetic on the operands.
module tb_bcd_serial_addsub;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int unsigned bcd_val(input logic [W-1:0] v);
    int unsigned r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int unsigned n);
    logic [W-1:0] r = '0;
    int unsigned  m = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, ":busy"},   32'(bus.busy),   32'd0);
    check_eq({tag, ":done"},   32'(bus.done),   32'd0);
    check_eq({tag, ":result"}, 32'(bus.result), 32'd0);
    check_eq({tag, ":cout"},   32'(bus.cout),   32'd0);
    check_eq({tag, ":neg"},    32'(bus.neg),    32'd0);
    check_eq({tag, ":err"},    32'(bus.err),    32'd0);
  endtask

  // Issue one operation from IDLE and check latency, busy length and results.
  // poke: raise start again (different operands) two cycles in while busy.
  task automatic run_op(input string name, input logic o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input bit poke);
    int unsigned  ea, eb, modulus, e_lat, e_busy, cyc, busy_n;
    logic [W-1:0] e_res;
    bit           e_cout, e_neg, e_err;

    modulus = 1;
    for (int i = 0; i < DIGITS; i++) modulus = modulus * 10;
    ea = bcd_val(av);
    eb = bcd_val(bv);
    e_cout = 1'b0;
    e_neg  = 1'b0;
    e_err  = has_bad(av) || has_bad(bv);
    if (e_err) begin
      e_res  = '0;
      e_lat  = 1;
      e_busy = 0;
    end else if (!o) begin
      e_res  = to_bcd((ea + eb) % modulus);
      e_cout = (ea + eb) >= modulus;
      e_lat  = DIGITS + 1;
      e_busy = DIGITS;
    end else if (ea >= eb) begin
      e_res  = to_bcd(ea - eb);
      e_lat  = DIGITS + 1;
      e_busy = DIGITS;
    end else begin
      e_res  = to_bcd(eb - ea);
      e_neg  = 1'b1;
      e_lat  = 2 * DIGITS + 1;
      e_busy = 2 * DIGITS;
    end

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.op    = 1'($urandom);
    cyc    = 1;
    busy_n = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) busy_n++;
      if (poke && cyc == 2) begin
        bus.start = 1'b1;
        bus.op    = ~o;
        bus.a     = rand_bcd();
        bus.b     = rand_bcd();
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check_eq({name, ":done"},    32'(bus.done),   32'd1);
    check_eq({name, ":latency"}, cyc,             e_lat);
    check_eq({name, ":busy_n"},  busy_n,          e_busy);
    check_eq({name, ":busy@done"}, 32'(bus.busy), 32'd0);
    check_eq({name, ":result"},  32'(bus.result), 32'(e_res));
    check_eq({name, ":cout"},    32'(bus.cout),   32'(e_cout));
    check_eq({name, ":neg"},     32'(bus.neg),    32'(e_neg));
    check_eq({name, ":err"},     32'(bus.err),    32'(e_err));
    @(negedge clk);
    check_eq({name, ":pulse"},   32'(bus.done),   32'd0);
    check_eq({name, ":hold"},    32'(bus.result), 32'(e_res));
    check_eq({name, ":holdneg"}, 32'({bus.cout, bus.neg, bus.err}),
             32'({e_cout, e_neg, e_err}));
  endtask

  initial begin
    int unsigned cyc;
    bit          done_seen;
    logic [W-1:0] ra, rb;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    run_op("add_1234_5678", 1'b0, 16'h1234, 16'h5678, 1'b0);
    run_op("add_9999_0001", 1'b0, 16'h9999, 16'h0001, 1'b0);
    run_op("sub_5000_1234", 1'b1, 16'h5000, 16'h1234, 1'b0);
    run_op("sub_1234_5000", 1'b1, 16'h1234, 16'h5000, 1'b0);
    run_op("sub_0042_0042", 1'b1, 16'h0042, 16'h0042, 1'b0);
    run_op("err_12A4",      1'b0, 16'h12A4, 16'h0003, 1'b0);
    run_op("poke_add",      1'b0, 16'h1234, 16'h5678, 1'b1);
    run_op("after_poke",    1'b1, 16'h0100, 16'h0999, 1'b0);

    // Reset in the middle of the complement pass.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h5000;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_fix:busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst_fix");
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    check_eq("rst_fix:no_done", 32'(done_seen), 32'd0);
    run_op("post_rst_add", 1'b0, 16'h0001, 16'h0001, 1'b0);

    // Randomized operations, with occasional equal operands, bad digits and pokes.
    for (int n = 0; n < 150; n++) begin
      ra = rand_bcd();
      rb = ($urandom_range(0, 9) == 0) ? ra : rand_bcd();
      if ($urandom_range(0, 11) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 11) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      run_op($sformatf("rand%0d", n), 1'($urandom), ra, rb, ($urandom_range(0, 4) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
